// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_edge block.
//
// Contents:
//   - 2-bit state encoding for the debounce FSM. Bit 1 of the encoding is
//     the debounced level, so IDLE_HI and WAIT_LO both present data_out = 1.
//   - Default number of stable samples required before the output flips.
//   - state_level(): the debounced level implied by a state code.
package debounce_pkg;

  localparam logic [1:0] IDLE_LO = 2'b00;
  localparam logic [1:0] WAIT_HI = 2'b01;
  localparam logic [1:0] IDLE_HI = 2'b11;
  localparam logic [1:0] WAIT_LO = 2'b10;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

  // Debounced level carried by a state: high in IDLE_HI and WAIT_LO.
  function automatic logic state_level(input logic [1:0] state);
    return state[1];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//
// Ports:
//   clk   - rising-edge clock of the destination domain
//   reset - asynchronous, active-low reset; both flops clear to 0
//   d     - asynchronous input level
//   q     - synchronized level, two clk edges behind d
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/debounce_edge.sv
// Debouncer with edge strobes for a bouncy asynchronous level (button/switch).
//
// data_out flips on the STABLE_CYCLES-th consecutive rising edge at which the
// sampled level s shows the new value. Any sample of the old level before that
// point drops the FSM back to its idle state without touching the outputs.
//
// Build option:
//   DEBOUNCE_SYNC_EN - when defined, data_in passes through a sync_2ff before
//                      being sampled (two extra cycles of latency). When not
//                      defined, data_in must already be synchronous to clk.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-low reset (0 = reset asserted)
//   data_in  - raw level
//   data_out - debounced level
//   rise     - one-cycle strobe aligned with data_out going 0->1
//   fall     - one-cycle strobe aligned with data_out going 1->0
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned  STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  localparam int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic data_out,
  output logic rise,
  output logic fall
);

  if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
    $error("debounce_edge: STABLE_CYCLES must be at least 2");
  end

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (data_in),
    .q     (s)
  );
`else
  assign s = data_in;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // cnt holds how many consecutive samples of the new level have been seen,
  // so it never exceeds STABLE_CYCLES-1 and cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The debounced level is encoded in the state, so it updates on the same
  // edge as the strobes.
  assign data_out = state_level(state_q);
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge (STABLE_CYCLES = 4). Works with or without
// DEBOUNCE_SYNC_EN; only the flip edge index changes.
module tb_debounce_edge;

  localparam int unsigned Stable = 4;

  // Edge index (counting the first edge after data_in changes as 1) at which
  // data_out flips.
`ifdef DEBOUNCE_SYNC_EN
  localparam int FlipEdge = Stable + 2;
`else
  localparam int FlipEdge = Stable;
`endif

  logic clk;
  logic reset;
  logic data_in;
  logic data_out;
  logic rise;
  logic fall;

  int checks;
  int errors;

  debounce_edge #(
    .STABLE_CYCLES (Stable)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .rise     (rise),
    .fall     (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic exp_out, input logic exp_rise,
                            input logic exp_fall);
    check_eq({tag, "_out"}, data_out, exp_out);
    check_eq({tag, "_rise"}, rise, exp_rise);
    check_eq({tag, "_fall"}, fall, exp_fall);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input already changed before the next edge; walk through the flip and one
  // cycle beyond, checking level and strobes at every edge.
  task automatic expect_flip(input string tag, input logic to_hi);
    for (int k = 1; k <= FlipEdge + 1; k++) begin
      tick();
      check_outs(tag, (k >= FlipEdge) ? to_hi : !to_hi,
                 to_hi && (k == FlipEdge), !to_hi && (k == FlipEdge));
    end
  endtask

  // Hold data_in for n cycles, expecting the outputs to stay quiet.
  task automatic hold_quiet(input string tag, input logic lvl, input logic exp_out, input int n);
    data_in = lvl;
    for (int k = 0; k < n; k++) begin
      tick();
      check_outs(tag, exp_out, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic bounce_pat [10];

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    data_in = 1'b0;
    bounce_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held for 20 ns.
    #2;
    check_outs("rst_early", 1'b0, 1'b0, 1'b0);
    #18;
    reset = 1'b1;
    hold_quiet("post_rst", 1'b0, 1'b0, 3);

    // Clean rising step just after an edge.
    data_in = 1'b1;
    expect_flip("step_rise", 1'b1);

    // Asynchronous reset mid-cycle while data_out is high.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("in_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    // Released with data_in still high: a normal debounce to 1.
    expect_flip("rel_rise", 1'b1);

    // Fall path.
    data_in = 1'b0;
    expect_flip("step_fall", 1'b0);

    // Bounce shorter than the stability window is rejected.
    for (int k = 0; k < 10; k++) begin
      data_in = bounce_pat[k];
      tick();
      check_outs("bounce", 1'b0, 1'b0, 1'b0);
    end
    data_in = 1'b1;
    expect_flip("bounce_rise", 1'b1);
    hold_quiet("hi_hold", 1'b1, 1'b1, 3);

    data_in = 1'b0;
    expect_flip("bounce_fall", 1'b0);

    // Toggling every cycle never settles.
    for (int k = 0; k < 16; k++) begin
      data_in = ~data_in;
      tick();
      check_outs("toggle", 1'b0, 1'b0, 1'b0);
    end
    hold_quiet("settle", 1'b0, 1'b0, 4);

    // Reset in the middle of a pending rise aborts it.
    hold_quiet("midwait_pre", 1'b1, 1'b0, 3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outs("midwait_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    expect_flip("midwait_rise", 1'b1);
    hold_quiet("midwait_post", 1'b1, 1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
